uart_rx_wb_writer: RTL
======================

Name: uart_rx_wb_writer

Overview:
- Sits between the BLE uart_rx and servant_ram, and replaces the ad-hoc rx/CPU mux in the top level.
- Buffers received bytes in a small FIFO and writes each byte into a circular RAM window [ADR_LL, ADR_UL) as a proper single-byte Wishbone write.
- Arbitrates the single RAM port between the servant CPU bus and its own write engine with round-robin fairness, so neither side starves and no byte is lost silently.

Parameters:
DEPTH, 16, FIFO depth in bytes (power of two, >=2)
ADR_LL, 32'h00C00000, first byte address of rx window (inclusive, word aligned)
ADR_UL, 32'h00C10000, end of rx window (exclusive, word aligned, > ADR_LL)

Ports:
i_wb_clk  in  1  system clock
i_wb_rst  in  1  reset, synchronous, active-high
i_rx_done  in  1  one-cycle strobe: i_rx_data valid
i_rx_data  in  8  received byte
i_cpu_adr  in  32  CPU Wishbone address
i_cpu_dat  in  32  CPU write data
i_cpu_sel  in  4  CPU byte enables
i_cpu_we  in  1  CPU write enable
i_cpu_cyc  in  1  CPU cycle request (held until ack)
o_cpu_rdt  out  32  read data to CPU
o_cpu_ack  out  1  ack to CPU
o_ram_adr  out  32  RAM address
o_ram_dat  out  32  RAM write data
o_ram_sel  out  4  RAM byte enables
o_ram_we  out  1  RAM write enable
o_ram_cyc  out  1  RAM cycle
i_ram_rdt  in  32  RAM read data
i_ram_ack  in  1  RAM ack
o_wr_ptr  out  32  byte address of next rx write
o_count  out  clog2(DEPTH+1)  FIFO occupancy
o_overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset (sync, i_wb_rst high at edge): state IDLE, FIFO empty, o_count=0, o_wr_ptr=ADR_LL, o_overflow=0, last_grant=DMA.
  - All o_ram_* and o_cpu_ack are 0 while in IDLE, so they are 0 from the first cycle after reset.
  - Reset mid-transaction abandons it; the byte is not popped and the pointer does not advance.
- FIFO:
  - Push on i_rx_done when count<DEPTH, or when count==DEPTH and a pop happens the same cycle.
  - Otherwise the byte is dropped and o_overflow is set; it clears only on reset.
  - Push and pop in the same cycle leave count unchanged. Pushing into an empty FIFO makes the byte eligible for grant the next cycle.
- Arbiter FSM states: IDLE, CPU, DMA.
  - IDLE, one request: CPU if i_cpu_cyc; DMA if count>0.
  - IDLE, both requesting: grant the side not granted last; update last_grant.
  - IDLE always lasts at least one cycle between transactions (bus idle cycle).
- CPU state:
  - o_ram_adr/dat/sel/we = CPU inputs, o_ram_cyc = i_cpu_cyc, all combinational.
  - o_cpu_ack = i_ram_ack, o_cpu_rdt = i_ram_rdt.
  - On i_ram_ack -> IDLE. If i_cpu_cyc drops before ack -> IDLE.
  - Outside CPU state, o_cpu_ack=0 and o_cpu_rdt=0.
- DMA state:
  - o_ram_cyc=1, o_ram_we=1.
  - o_ram_adr = {o_wr_ptr[31:2],2'b00}; o_ram_sel = 4'b0001 << o_wr_ptr[1:0]; o_ram_dat = {4{head byte}}.
  - Signals are held stable until i_ram_ack.
  - On ack: pop FIFO, advance o_wr_ptr, -> IDLE.
- Pointer: increments by 1 per written byte; if the result == ADR_UL it becomes ADR_LL (wrap-around, never writes ADR_UL).
- Latency: rx byte into empty FIFO with idle CPU and 1-cycle RAM ack: i_rx_done at edge N, o_ram_cyc high from N+2, ack at N+3, pop/pointer update at edge N+3.
- CPU latency adds nothing beyond RAM ack, except waiting out at most one DMA transaction plus the IDLE cycle.

Test Plan:
- Single byte: reset, i_rx_done with 8'h41, CPU idle -> one write, adr=32'h00C00000, sel=4'b0001, dat=32'h41414141; o_wr_ptr=32'h00C00001, o_count back to 0.
- Byte lanes: bytes 11,22,33,44,55 -> sel 0001,0010,0100,1000 at adr 00C00000, then sel 0001 at 00C00004; RAM word 0 reads 32'h44332211.
- Wrap: ADR_UL=ADR_LL+8, send 10 bytes -> writes to byte addresses LL..LL+7, then LL, LL+1; o_wr_ptr=LL+2.
- Overflow: DEPTH=4, i_ram_ack held 0, send 6 bytes -> o_count=4, o_overflow=1; release ack -> exactly first 4 bytes written in order; o_overflow stays 1 until reset.
- Fairness: i_cpu_cyc held with back-to-back reads while 3 bytes are queued -> grants alternate CPU, DMA, CPU, DMA, ...; every CPU read returns correct RAM data with o_cpu_ack exactly one cycle per transaction.
- Reset mid-DMA: assert i_wb_rst while in DMA before ack -> next cycle o_ram_cyc=0, o_count=0, o_wr_ptr=ADR_LL; a new byte after reset is written at ADR_LL.

Source files
------------

// File: rtl/uart_rx_wb_writer.sv
// Buffers UART rx bytes in a FIFO and writes them as single-byte Wishbone writes into a circular RAM window,
// sharing the one RAM port with the CPU through a round-robin arbiter.
//
// state | meaning
// IDLE  | bus idle cycle; picks the next owner of the RAM port
// CPU   | CPU bus passed through to RAM until ack (or the CPU drops cyc)
// DMA   | head FIFO byte written to RAM at o_wr_ptr; held until ack

`timescale 1ns/1ps

module uart_rx_wb_writer #(
   parameter int          DEPTH  = 16,
   parameter logic [31:0] ADR_LL = 32'h00C00000,
   parameter logic [31:0] ADR_UL = 32'h00C10000
) (
   input  logic                       i_wb_clk,
   input  logic                       i_wb_rst,
   input  logic                       i_rx_done,
   input  logic [7:0]                 i_rx_data,
   input  logic [31:0]                i_cpu_adr,
   input  logic [31:0]                i_cpu_dat,
   input  logic [3:0]                 i_cpu_sel,
   input  logic                       i_cpu_we,
   input  logic                       i_cpu_cyc,
   output logic [31:0]                o_cpu_rdt,
   output logic                       o_cpu_ack,
   output logic [31:0]                o_ram_adr,
   output logic [31:0]                o_ram_dat,
   output logic [3:0]                 o_ram_sel,
   output logic                       o_ram_we,
   output logic                       o_ram_cyc,
   input  logic [31:0]                i_ram_rdt,
   input  logic                       i_ram_ack,
   output logic [31:0]                o_wr_ptr,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CPU,
      S_DMA
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          last_dma;
   logic          last_dma_nxt;

   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    head;
   logic [31:0]   ptr_inc;

   assign fifo_full  = (o_count == CW'(DEPTH));
   assign fifo_empty = (o_count == '0);
   assign pop        = (state == S_DMA) && i_ram_ack;
   // A full FIFO still takes a byte when the head leaves on the same edge.
   assign push       = i_rx_done && (!fifo_full || pop);
   assign head       = fifo_mem[rd_idx];
   assign ptr_inc    = o_wr_ptr + 32'd1;

   always_ff @(posedge i_wb_clk) begin
      if (push) begin
         fifo_mem[wr_idx] <= i_rx_data;
      end
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         state      <= S_IDLE;
         last_dma   <= 1'b1;
         rd_idx     <= '0;
         wr_idx     <= '0;
         o_count    <= '0;
         o_wr_ptr   <= ADR_LL;
         o_overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_dma <= last_dma_nxt;
         if (push) begin
            wr_idx <= wr_idx + 1'b1;
         end
         if (pop) begin
            rd_idx   <= rd_idx + 1'b1;
            o_wr_ptr <= (ptr_inc == ADR_UL) ? ADR_LL : ptr_inc;
         end
         if (push && !pop) begin
            o_count <= o_count + 1'b1;
         end else if (pop && !push) begin
            o_count <= o_count - 1'b1;
         end
         if (i_rx_done && !push) begin
            o_overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      last_dma_nxt = last_dma;
      o_ram_adr    = 32'h0;
      o_ram_dat    = 32'h0;
      o_ram_sel    = 4'h0;
      o_ram_we     = 1'b0;
      o_ram_cyc    = 1'b0;
      o_cpu_ack    = 1'b0;
      o_cpu_rdt    = 32'h0;
      case (state)
         S_IDLE: begin
            if (i_cpu_cyc && !fifo_empty) begin
               // Contention: the side that did not win last time goes first.
               if (last_dma) begin
                  state_nxt    = S_CPU;
                  last_dma_nxt = 1'b0;
               end else begin
                  state_nxt    = S_DMA;
                  last_dma_nxt = 1'b1;
               end
            end else if (i_cpu_cyc) begin
               state_nxt    = S_CPU;
               last_dma_nxt = 1'b0;
            end else if (!fifo_empty) begin
               state_nxt    = S_DMA;
               last_dma_nxt = 1'b1;
            end
         end
         S_CPU: begin
            o_ram_adr = i_cpu_adr;
            o_ram_dat = i_cpu_dat;
            o_ram_sel = i_cpu_sel;
            o_ram_we  = i_cpu_we;
            o_ram_cyc = i_cpu_cyc;
            o_cpu_ack = i_ram_ack;
            o_cpu_rdt = i_ram_rdt;
            if (i_ram_ack || !i_cpu_cyc) begin
               state_nxt = S_IDLE;
            end
         end
         S_DMA: begin
            o_ram_adr = {o_wr_ptr[31:2], 2'b00};
            o_ram_dat = {4{head}};
            o_ram_sel = 4'b0001 << o_wr_ptr[1:0];
            o_ram_we  = 1'b1;
            o_ram_cyc = 1'b1;
            if (i_ram_ack) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
